// File: rtl/stack_arbiter.sv
// stack_arbiter: grants one of two requesters (0 = control unit, 1 = interrupt unit)
// exclusive use of an external stack for one push or pop per grant.
//
// Optional feature macro: STACK_ARB_RR_EN
//   defined   -> round-robin tie-break between simultaneous requests
//   undefined -> fixed priority, requester 0 wins ties (default build)
//
// Ports:
//   clk, clr_n               clock, asynchronous active-low reset
//   req0/req1, op0/op1       requests and operation (1 = push, 0 = pop)
//   wdata0/wdata1            push data
//   gnt0/gnt1                ownership, one-hot or zero
//   done, err, rdata         one-cycle completion pulse, refusal flag, stack top after op
//   busy                     high whenever the FSM is not idle
//   stk_c, stk_en, stk_push  stack control, enable strobe and push data
//   stk_peek, stk_full,
//   stk_not_empty            stack top value and status flags
//
// Timing: every output is a register written by the state whose action it is,
// so stk_en is high the cycle after the ISSUE evaluation and done lands
// 3 cycles after the grant (2 for a refused op).
module stack_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             stk_c,
  output logic             stk_en,
  output logic [WIDTH-1:0] stk_push,
  input  logic [WIDTH-1:0] stk_peek,
  input  logic             stk_full,
  input  logic             stk_not_empty
);

  typedef enum logic [1:0] {StIdle, StIssue, StSettle, StResp} state_e;

  state_e           r_state;
  logic             r_op;
  logic [WIDTH-1:0] r_wdata;
  logic             r_err_flag;
  logic             r_gnt0, r_gnt1, r_done, r_err, r_busy, r_stk_c, r_stk_en;
  logic [WIDTH-1:0] r_rdata, r_stk_push;

  logic w_pick1;
  logic w_legal;

`ifdef STACK_ARB_RR_EN
  // Requester favoured on a tie; points away from whoever was granted last.
  logic r_prio;
  assign w_pick1 = req1 & (~req0 | r_prio);
`else
  assign w_pick1 = req1 & ~req0;
`endif

  assign w_legal = r_op ? ~stk_full : stk_not_empty;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= StIdle;
      r_op       <= 1'b0;
      r_wdata    <= '0;
      r_err_flag <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_stk_c    <= 1'b0;
      r_stk_en   <= 1'b0;
      r_stk_push <= '0;
`ifdef STACK_ARB_RR_EN
      r_prio     <= 1'b0;
`endif
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_stk_en   <= 1'b0;
      r_stk_c    <= 1'b0;
      r_stk_push <= '0;
      unique case (r_state)
        StIdle: begin
          if (req0 | req1) begin
            r_gnt0     <= ~w_pick1;
            r_gnt1     <= w_pick1;
            r_busy     <= 1'b1;
            r_op       <= w_pick1 ? op1 : op0;
            r_wdata    <= w_pick1 ? wdata1 : wdata0;
            r_err_flag <= 1'b0;
            r_state    <= StIssue;
`ifdef STACK_ARB_RR_EN
            r_prio     <= ~w_pick1;
`endif
          end
        end
        StIssue: begin
          if (w_legal) begin
            r_stk_en   <= 1'b1;
            r_stk_c    <= r_op;
            r_stk_push <= r_wdata;
            r_state    <= StSettle;
          end else begin
            r_err_flag <= 1'b1;
            r_state    <= StResp;
          end
        end
        // Stack applies the op on this edge; peek/flags settle before StResp.
        StSettle: r_state <= StResp;
        StResp: begin
          r_done  <= 1'b1;
          r_err   <= r_err_flag;
          r_rdata <= stk_peek;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign done     = r_done;
  assign err      = r_err;
  assign rdata    = r_rdata;
  assign busy     = r_busy;
  assign stk_c    = r_stk_c;
  assign stk_en   = r_stk_en;
  assign stk_push = r_stk_push;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: a 4-deep behavioural stack as the environment, a table of
// directed transactions, hand-written reset/arbitration sequences, and randomized
// transactions checked against a queue-based reference model.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       req0, req1, op0, op1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, done, err, busy, stk_c, stk_en;
  logic [7:0] rdata, stk_push, stk_peek;
  logic       stk_full, stk_not_empty;

  stack_arbiter #(.WIDTH(8)) dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .req0          (req0),
    .req1          (req1),
    .op0           (op0),
    .op1           (op1),
    .wdata0        (wdata0),
    .wdata1        (wdata1),
    .gnt0          (gnt0),
    .gnt1          (gnt1),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .busy          (busy),
    .stk_c         (stk_c),
    .stk_en        (stk_en),
    .stk_push      (stk_push),
    .stk_peek      (stk_peek),
    .stk_full      (stk_full),
    .stk_not_empty (stk_not_empty)
  );

  always #5 clk = ~clk;

  // Environment stack, 4 deep, not affected by the arbiter reset.
  logic [7:0] s_mem [4];
  logic [2:0] s_cnt = 3'd0;
  assign stk_full      = (s_cnt == 3'd4);
  assign stk_not_empty = (s_cnt != 3'd0);
  assign stk_peek      = (s_cnt == 3'd0) ? 8'h00 : s_mem[s_cnt[1:0] - 2'd1];

  always @(posedge clk) begin
    if (stk_en) begin
      if (stk_c && s_cnt != 3'd4) begin
        s_mem[s_cnt[1:0]] <= stk_push;
        s_cnt             <= s_cnt + 3'd1;
      end else if (!stk_c && s_cnt != 3'd0) begin
        s_cnt <= s_cnt - 3'd1;
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: stack contents and the requester favoured on a tie.
  logic [7:0] ref_q [$];
  int         prio = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_winner(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef STACK_ARB_RR_EN
      return prio;
`else
      return 0;
`endif
    end
    return r0 ? 0 : 1;
  endfunction

  task automatic model(input int w, input logic op, input logic [7:0] d,
                       output logic e, output logic [7:0] rd);
    e = op ? (ref_q.size() >= 4) : (ref_q.size() == 0);
    if (!e) begin
      if (op) ref_q.push_back(d);
      else void'(ref_q.pop_back());
    end
    rd   = (ref_q.size() != 0) ? ref_q[$] : 8'h00;
    prio = 1 - w;
  endtask

  // Runs one transaction starting just after a negedge and checks it completely.
  task automatic do_and_check(input string tag, input logic r0, input logic o0,
                              input logic [7:0] d0, input logic r1, input logic o1,
                              input logic [7:0] d1, input int ewin, input logic eerr,
                              input logic [7:0] erd);
    int         t, win, lat, en_cnt, en_bad, two_gnt;
    logic       wop, e;
    logic [7:0] wd, rd;
    req0 = r0; op0 = o0; wdata0 = d0;
    req1 = r1; op1 = o1; wdata1 = d1;
    win = -1; lat = -1; en_cnt = 0; en_bad = 0; two_gnt = 0; e = 1'bx; rd = 8'hxx;
    t = 0;
    do begin @(negedge clk); t++; end while (!(gnt0 || gnt1) && t < 8);
    if (gnt0 && gnt1) two_gnt++;
    if (gnt0) win = 0;
    else if (gnt1) win = 1;
    wop = (win == 1) ? o1 : o0;
    wd  = (win == 1) ? d1 : d0;
    // The winner drops req and scrambles op/data; the transaction must not notice.
    if (win == 0) begin req0 = 1'b0; op0 = ~o0; wdata0 = ~d0; end
    if (win == 1) begin req1 = 1'b0; op1 = ~o1; wdata1 = ~d1; end
    t = 0;
    while (win >= 0 && !done && t < 8) begin
      @(negedge clk);
      t++;
      if (gnt0 && gnt1) two_gnt++;
      if (stk_en) begin
        en_cnt++;
        if (stk_c !== wop || stk_push !== wd) en_bad++;
      end
    end
    if (done) begin lat = t; e = err; rd = rdata; end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk({tag, " winner"}, win, ewin);
    chk({tag, " latency"}, lat, eerr ? 2 : 3);
    chk({tag, " err"}, {31'd0, e}, {31'd0, eerr});
    chk({tag, " rdata"}, {24'd0, rd}, {24'd0, erd});
    chk({tag, " stk_en pulses"}, en_cnt, eerr ? 0 : 1);
    chk({tag, " stk_c/stk_push"}, en_bad, 0);
    chk({tag, " gnt overlap"}, two_gnt, 0);
    chk({tag, " done width"}, {31'd0, done}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt0"}, {31'd0, gnt0}, 0);
    chk({tag, " gnt1"}, {31'd0, gnt1}, 0);
    chk({tag, " done"}, {31'd0, done}, 0);
    chk({tag, " err"}, {31'd0, err}, 0);
    chk({tag, " busy"}, {31'd0, busy}, 0);
    chk({tag, " stk_en"}, {31'd0, stk_en}, 0);
    chk({tag, " stk_c"}, {31'd0, stk_c}, 0);
    chk({tag, " stk_push"}, {24'd0, stk_push}, 0);
    chk({tag, " rdata"}, {24'd0, rdata}, 0);
  endtask

  typedef struct {
    logic       r0, o0;
    logic [7:0] d0;
    logic       r1, o1;
    logic [7:0] d1;
    int         win;
    logic       err;
    logic [7:0] rd;
  } vec_t;

  initial begin
    vec_t       tbl [11];
    int         t, ew;
    logic       e, r0, r1, o0, o1, wop;
    logic [7:0] rd, d0, d1, wd;

    // Stack starts empty; 4 deep.
    tbl[0]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'hA5}; // push A5
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1, 1'b0, 8'h00}; // pop -> empty
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1, 1'b1, 8'h00}; // pop on empty
    tbl[3]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h11};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1, 1'b0, 8'h22};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h11}; // pop 22
    tbl[6]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h33};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 1, 1'b0, 8'h44};
    tbl[8]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h55}; // now full
    tbl[9]  = '{1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h55}; // push on full
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1, 1'b0, 8'h44};

    req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0; wdata0 = '0; wdata1 = '0;
    clr_n = 1'b1;
    #2 clr_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    clr_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_and_check($sformatf("vec%0d", i), tbl[i].r0, tbl[i].o0, tbl[i].d0,
                   tbl[i].r1, tbl[i].o1, tbl[i].d1, tbl[i].win, tbl[i].err, tbl[i].rd);
      wop = tbl[i].win == 1 ? tbl[i].o1 : tbl[i].o0;
      wd  = tbl[i].win == 1 ? tbl[i].d1 : tbl[i].d0;
      model(tbl[i].win, wop, wd, e, rd);
    end

    // Reset while the stack strobe is up: everything clears at once, no done.
    req0 = 1'b1; op0 = 1'b1; wdata0 = 8'h77;
    t = 0;
    do begin @(negedge clk); t++; end while (!gnt0 && t < 8);
    @(negedge clk);
    chk("mid-reset stk_en before", {31'd0, stk_en}, 1);
    #2 clr_n = 1'b0;
    #1 chk_all_zero("mid-reset async");
    req0 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid-reset no done", {31'd0, done}, 0);
    end
    clr_n = 1'b1;
    prio  = 0;

    // Both requesting on every transaction right after reset.
    for (int k = 0; k < 4; k++) begin
`ifdef STACK_ARB_RR_EN
      ew = k % 2;
`else
      ew = 0;
`endif
      chk($sformatf("tie%0d model winner", k), exp_winner(1'b1, 1'b1), ew);
      wop = (ew == 1) ? 1'b0 : 1'b1;
      wd  = (ew == 1) ? 8'hB0 + 8'(k) : 8'hC0 + 8'(k);
      model(ew, wop, wd, e, rd);
      do_and_check($sformatf("tie%0d", k), 1'b1, 1'b1, 8'hC0 + 8'(k),
                   1'b1, 1'b0, 8'hB0 + 8'(k), ew, e, rd);
    end

    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      o0 = 1'($urandom_range(0, 1));
      o1 = 1'($urandom_range(0, 1));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      ew  = exp_winner(r0, r1);
      wop = (ew == 1) ? o1 : o0;
      wd  = (ew == 1) ? d1 : d0;
      model(ew, wop, wd, e, rd);
      do_and_check($sformatf("rnd%0d", i), r0, o0, d0, r1, o1, d1, ew, e, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
